// File: rtl/mem_block_copier_pkg.sv
// Shared encodings and defaults for the block copier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_block_copier_pkg;

    localparam int MEM_DEPTH_DEF = 101;
    localparam int LEN_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_addr_chk.sv
// Word address generator: base + idx with 32-bit wrap and memory range check.
// Latency: combinational.
// Backpressure: none; ok low means the address must not be strobed.
module mem_copy_addr_chk
    import mem_block_copier_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int IDX_W     = LEN_W_DEF
) (
    input  logic [31:0]      base,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      addr,
    output logic             ok
);

    logic [32:0] sum;

    // Carry out of the 33-bit sum flags a wrapped address.
    always_comb begin
        sum  = {1'b0, base} + 33'(idx);
        addr = sum[31:0];
        ok   = !sum[32] && (sum[31:0] < 32'(MEM_DEPTH));
    end

endmodule

// File: rtl/mem_block_copier.sv
// Block copier: reads LEN words from src_base and writes them to dst_base, one read + one write cycle per word.
// Latency: busy the cycle after start; done 2*len+1 cycles after the start edge (1 for len==0).
// Backpressure: none; start is ignored outside IDLE. Optional MEM_COPY_CHECKSUM_EN adds a running checksum.
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_base,
    input  logic [31:0]      dst_base,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      ad,
    output logic [31:0]      wr,
    output logic             memtowrite,
    output logic             memtoread,
    input  logic [31:0]      read
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      data_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_inc;
    logic [LEN_W-1:0] src_idx;
    logic [31:0]      src_b;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic             src_ok;
    logic             dst_ok;

    // In IDLE the first source address comes straight from the start inputs;
    // in WRITE the source checker looks one word ahead for the next READ.
    assign idx_inc = idx + 1'b1;
    assign src_b   = (state == ST_IDLE) ? src_base : src_q;
    assign src_idx = (state == ST_IDLE) ? '0 : idx_inc;
    assign wr      = data_q;

    mem_copy_addr_chk #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(LEN_W)) u_src_chk (
        .base (src_b),
        .idx  (src_idx),
        .addr (src_addr),
        .ok   (src_ok)
    );

    mem_copy_addr_chk #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(LEN_W)) u_dst_chk (
        .base (dst_q),
        .idx  (idx),
        .addr (dst_addr),
        .ok   (dst_ok)
    );

    // Copy FSM; every output is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ad         <= '0;
            data_q     <= '0;
            memtowrite <= 1'b0;
            memtoread  <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    memtoread  <= 1'b0;
                    memtowrite <= 1'b0;
                    if (start) begin
                        src_q <= src_base;
                        dst_q <= dst_base;
                        len_q <= len;
                        idx   <= '0;
                        if (len == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (src_ok) begin
                            state     <= ST_READ;
                            busy      <= 1'b1;
                            ad        <= src_addr;
                            memtoread <= 1'b1;
                        end else begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    data_q    <= read;
                    memtoread <= 1'b0;
                    if (dst_ok) begin
                        state      <= ST_WRITE;
                        ad         <= dst_addr;
                        memtowrite <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    memtowrite <= 1'b0;
                    idx        <= idx_inc;
                    if (idx_inc == len_q) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (src_ok) begin
                        state     <= ST_READ;
                        ad        <= src_addr;
                        memtoread <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    // Running sum of written words; cleared on an accepted start, held after done/err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == ST_IDLE && start) begin
            checksum <= '0;
        end else if (state == ST_WRITE) begin
            checksum <= checksum + data_q;
        end
    end
`else
    // No checksum accumulator in this build.
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: directed copies against a preloaded combinational memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_block_copier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ad;
    logic [31:0] wr;
    logic        memtowrite;
    logic        memtoread;
    logic [31:0] read;
    logic [31:0] ck;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
    assign ck = checksum;
`else
    assign ck = 32'd0;
`endif

    mem_block_copier #(.MEM_DEPTH(101), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ad         (ad),
        .wr         (wr),
        .memtowrite (memtowrite),
        .memtoread  (memtoread),
        .read       (read)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write committed on the clock edge.
    logic [31:0] mem [0:100];
    logic        reload = 1'b0;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0: return 32'd4;
            1: return 32'd6;
            2: return 32'd9;
            3: return 32'd2;
            4: return 32'd7;
            5: return 32'd8;
            6: return 32'd1;
            7: return 32'd3;
            8: return 32'd5;
            9: return 32'd10;
            default: begin
                if (i < 20) return 32'd0;
                else if (i < 50) return 32'd777;
                else return 32'(i - 50);
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < 101; i++) mem[i] <= init_val(i);
        end else if (memtowrite && ad < 32'd101) begin
            mem[ad[6:0]] <= wr;
        end
    end

    assign read = (ad < 32'd101) ? mem[ad[6:0]] : 32'hDEAD_BEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_cnt       = 0;
    bit mon_en       = 1'b0;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 err
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int k, input logic [31:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none (cycle %0d)", k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (k == 0) begin
                check("write_addr", a, e.a);
                check("write_data", d, e.d);
            end else begin
                check("end_cycle", 32'(cyc), 32'(e.c));
`ifdef MEM_COPY_CHECKSUM_EN
                if (k == 1) check("checksum", d, e.d);
`endif
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, done or err.
    always @(negedge clk) begin
        logic [31:0] ad_s;
        if (mon_en) begin
            check("strobe_excl", {31'd0, memtoread & memtowrite}, 32'd0);
            if (memtoread) rd_cnt++;
            if (memtowrite) expect_ev(0, ad, wr);
            if (done) expect_ev(1, 32'd0, ck);
            if (err) expect_ev(2, 32'd0, 32'd0);
            if (done || err) check("busy_at_end", {31'd0, busy}, 32'd0);
            if (memtoread || memtowrite) begin
                ad_s = ad;
                #4;
                check("ad_stable", ad, ad_s);
            end
        end
    end

    task automatic reload_mem();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1 [10];
        int c0;
        int rd0;
        t1 = '{32'd4, 32'd6, 32'd9, 32'd2, 32'd7, 32'd8, 32'd1, 32'd3, 32'd5, 32'd10};

        rst_n    = 1'b0;
        start    = 1'b0;
        src_base = '0;
        dst_base = '0;
        len      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ad", ad, 32'd0);
        check("rst_wr", wr, 32'd0);
        check("rst_memtowrite", {31'd0, memtowrite}, 32'd0);
        check("rst_memtoread", {31'd0, memtoread}, 32'd0);
        check("rst_checksum", ck, 32'd0);
        mon_en = 1'b1;

        // 1: src=0 dst=20 len=10
        reload_mem();
        @(negedge clk);
        c0 = cyc + 1;
        rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) push_ev(0, 32'(20 + i), t1[i], 0);
        push_ev(1, 0, 32'd55, c0 + 20);
        src_base = 32'd0; dst_base = 32'd20; len = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        drain(60);
        check("t1_reads", 32'(rd_cnt - rd0), 32'd10);
        for (int i = 0; i < 10; i++) check("t1_mem", mem[20 + i], t1[i]);

        // 2: len=0 -> done next cycle, no access
        reload_mem();
        @(negedge clk);
        c0 = cyc + 1;
        rd0 = rd_cnt;
        push_ev(1, 0, 32'd0, c0);
        src_base = 32'd0; dst_base = 32'd20; len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(10);
        check("t2_reads", 32'(rd_cnt - rd0), 32'd0);
        for (int i = 20; i < 50; i++) check("t2_mem", mem[i], 32'd777);

        // 3: src=95 dst=30 len=10 -> six words, then err on source 101
        reload_mem();
        @(negedge clk);
        c0 = cyc + 1;
        for (int i = 0; i < 6; i++) push_ev(0, 32'(30 + i), 32'(45 + i), 0);
        push_ev(2, 0, 0, c0 + 12);
        src_base = 32'd95; dst_base = 32'd30; len = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(40);
        check("t3_mem35", mem[35], 32'd50);
        check("t3_mem36", mem[36], 32'd777);

        // 4: second start 3 cycles into a len=5 copy is ignored
        reload_mem();
        @(negedge clk);
        c0 = cyc + 1;
        for (int i = 0; i < 5; i++) push_ev(0, 32'(60 + i), t1[i], 0);
        push_ev(1, 0, 32'd28, c0 + 10);
        src_base = 32'd0; dst_base = 32'd60; len = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        src_base = 32'd50; dst_base = 32'd20; len = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(40);
        check("t4_mem20", mem[20], 32'd777);

        // 5: reset during WRITE of idx 3 (src=50 dst=40 len=8)
        reload_mem();
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_ev(0, 32'(40 + i), 32'(i), 0);
        src_base = 32'd50; dst_base = 32'd40; len = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_in_write_idx3", {31'd0, memtowrite}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_memtowrite", {31'd0, memtowrite}, 32'd0);
        check("t5_memtoread", {31'd0, memtoread}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        drain(10);
        for (int i = 0; i < 3; i++) check("t5_mem_copied", mem[40 + i], 32'(i));
        for (int i = 44; i < 48; i++) check("t5_mem_untouched", mem[i], 32'd777);

        // 6: destination top word is the last valid address
        reload_mem();
        @(negedge clk);
        c0 = cyc + 1;
        for (int i = 0; i < 3; i++) push_ev(0, 32'(98 + i), t1[i], 0);
        push_ev(1, 0, 32'd19, c0 + 6);
        src_base = 32'd0; dst_base = 32'd98; len = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(20);

        // 7: destination out of range -> err before the first write strobe
        reload_mem();
        @(negedge clk);
        c0 = cyc + 1;
        rd0 = rd_cnt;
        push_ev(2, 0, 0, c0 + 1);
        src_base = 32'd0; dst_base = 32'hFFFF_FFFF; len = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(10);
        check("t7_reads", 32'(rd_cnt - rd0), 32'd1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
